// File: rtl/phy_tx_scheduler_pkg.sv
// Types and constants shared by the PHY transmit scheduler and its arbiter.
package phy_tx_scheduler_pkg;
`include "phy_defs.vh"

  localparam logic [31:0] COM_WORD  = `PHY_COM_WORD;
  localparam logic [31:0] IDLE_WORD = `PHY_IDLE_WORD;
  localparam logic [31:0] SKP_WORD  = `PHY_SKP_WORD;

  typedef enum logic {
    ST_SYNC   = `PHY_ST_SYNC,
    ST_ACTIVE = `PHY_ST_ACTIVE
  } state_e;

  // One-hot source ownership, {b,a}.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;
endpackage

// File: rtl/phy_defs.vh
// Shared PHY symbol constants and scheduler state encoding.
`ifndef PHY_DEFS_VH
`define PHY_DEFS_VH
`define PHY_COM_WORD  32'hBCBC_BCBC
`define PHY_IDLE_WORD 32'h7C7C_7C7C
`define PHY_SKP_WORD  32'h1C1C_1C1C
`define PHY_ST_SYNC   1'b0
`define PHY_ST_ACTIVE 1'b1
`endif

// File: rtl/phy_rr_arbiter.sv
// Burst-limited round-robin grant between sources A and B; no grant in a SKP slot.
module phy_rr_arbiter
  import phy_tx_scheduler_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int BW        = 3
) (
  input  logic          valid_a_i,
  input  logic          valid_b_i,
  input  logic [1:0]    owner_i,
  input  logic          last_b_i,
  input  logic [BW-1:0] burst_cnt_i,
  input  logic          skp_due_i,
  output logic [1:0]    grant_o
);

  logic burst_open;
  assign burst_open = (burst_cnt_i < BW'(BURST_MAX));

  always_comb begin
    grant_o = GNT_NONE;
    if (!skp_due_i) begin
      case (owner_i)
        GNT_A: begin
          if (valid_a_i && burst_open) grant_o = GNT_A;
          else if (valid_b_i)          grant_o = GNT_B;
          else if (valid_a_i)          grant_o = GNT_A;
        end
        GNT_B: begin
          if (valid_b_i && burst_open) grant_o = GNT_B;
          else if (valid_a_i)          grant_o = GNT_A;
          else if (valid_b_i)          grant_o = GNT_B;
        end
        default: begin
          // No owner: a tie goes to whichever source was not served last.
          if (valid_a_i && valid_b_i) grant_o = last_b_i ? GNT_A : GNT_B;
          else if (valid_a_i)         grant_o = GNT_A;
          else if (valid_b_i)         grant_o = GNT_B;
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_tx_scheduler.sv
// PHY transmit scheduler: COM sync preamble, then arbitrated source words with
// periodic SKP insertion and IDLE fill, all registered with one-cycle latency.
module phy_tx_scheduler
  import phy_tx_scheduler_pkg::*;
#(
  parameter int BURST_MAX    = 4,
  parameter int SKP_INTERVAL = 16,
  parameter int SYNC_WORDS   = 4
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        valid_a,
  input  logic        valid_b,
  output logic        ready_a,
  output logic        ready_b,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        kword_out,
  output logic [1:0]  grant_out,
  output logic        sync_done
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int KW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int SW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
  localparam logic [KW-1:0] SKP_LAST   = KW'(SKP_INTERVAL - 1);
  localparam logic [SW-1:0] SYNC_LAST  = SW'(SYNC_WORDS - 1);
  localparam logic [BW-1:0] BURST_FULL = BW'(BURST_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic [KW-1:0] skp_cnt_q, skp_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]    owner_q, owner_d;
  logic          last_b_q, last_b_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          kword_q, kword_d;
  logic [1:0]    grant_q, grant_d;
  logic          sync_done_q, sync_done_d;

  logic       active;
  logic       skp_due;
  logic [1:0] arb_grant;
  logic [1:0] grant;

  assign active  = (state_q == ST_ACTIVE);
  assign skp_due = active && (skp_cnt_q == SKP_LAST);

  phy_rr_arbiter #(
    .BURST_MAX (BURST_MAX),
    .BW        (BW)
  ) u_arb (
    .valid_a_i   (valid_a),
    .valid_b_i   (valid_b),
    .owner_i     (owner_q),
    .last_b_i    (last_b_q),
    .burst_cnt_i (burst_cnt_q),
    .skp_due_i   (skp_due),
    .grant_o     (arb_grant)
  );

  // Reset forces SYNC, so readies drop the instant reset asserts.
  assign grant   = active ? arb_grant : GNT_NONE;
  assign ready_a = grant[0];
  assign ready_b = grant[1];

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= '0;
      skp_cnt_q   <= '0;
      burst_cnt_q <= '0;
      owner_q     <= GNT_NONE;
      last_b_q    <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      kword_q     <= 1'b0;
      grant_q     <= GNT_NONE;
      sync_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      skp_cnt_q   <= skp_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      owner_q     <= owner_d;
      last_b_q    <= last_b_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      kword_q     <= kword_d;
      grant_q     <= grant_d;
      sync_done_q <= sync_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    skp_cnt_d   = skp_cnt_q;
    burst_cnt_d = burst_cnt_q;
    owner_d     = owner_q;
    last_b_d    = last_b_q;
    case (state_q)
      ST_SYNC: begin
        if (sync_cnt_q == SYNC_LAST) state_d = ST_ACTIVE;
        else                         sync_cnt_d = sync_cnt_q + 1'b1;
      end
      ST_ACTIVE: begin
        skp_cnt_d = skp_due ? '0 : skp_cnt_q + 1'b1;
        if (grant != GNT_NONE) begin
          owner_d     = grant;
          last_b_d    = grant[1];
          burst_cnt_d = (grant != owner_q || burst_cnt_q == BURST_FULL) ?
                        BW'(1) : burst_cnt_q + 1'b1;
        end else if (!skp_due) begin
          // An IDLE slot ends the burst; SKP slots leave it intact.
          owner_d     = GNT_NONE;
          burst_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    data_d      = IDLE_WORD;
    valid_d     = 1'b0;
    kword_d     = 1'b1;
    grant_d     = GNT_NONE;
    sync_done_d = sync_done_q;
    case (state_q)
      ST_SYNC: data_d = COM_WORD;
      ST_ACTIVE: begin
        sync_done_d = 1'b1;
        if (skp_due) begin
          data_d = SKP_WORD;
        end else if (grant != GNT_NONE) begin
          data_d  = grant[1] ? data_b : data_a;
          valid_d = 1'b1;
          kword_d = 1'b0;
          grant_d = grant;
        end
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign kword_out = kword_q;
  assign grant_out = grant_q;
  assign sync_done = sync_done_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Directed bench for phy_tx_scheduler with a reference model feeding an output scoreboard.
module tb_phy_tx_scheduler;

  localparam int BURST_MAX    = 4;
  localparam int SKP_INTERVAL = 16;
  localparam int SYNC_WORDS   = 4;

  logic        clk_2f;
  logic        reset;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b;
  logic [31:0] data_out;
  logic        valid_out, kword_out, sync_done;
  logic [1:0]  grant_out;

  phy_tx_scheduler #(
    .BURST_MAX    (BURST_MAX),
    .SKP_INTERVAL (SKP_INTERVAL),
    .SYNC_WORDS   (SYNC_WORDS)
  ) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .data_a    (data_a),
    .data_b    (data_b),
    .valid_a   (valid_a),
    .valid_b   (valid_b),
    .ready_a   (ready_a),
    .ready_b   (ready_b),
    .data_out  (data_out),
    .valid_out (valid_out),
    .kword_out (kword_out),
    .grant_out (grant_out),
    .sync_done (sync_done)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  typedef struct packed {
    logic [31:0] d;
    logic        v;
    logic        k;
    logic [1:0]  g;
    logic        s;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner/last are 0=none, 1=A, 2=B.
  int m_sync_left, m_skp, m_burst, m_owner, m_last;
  bit m_active;

  task automatic model_reset();
    m_sync_left = SYNC_WORDS;
    m_active    = 0;
    m_skp       = 0;
    m_burst     = 0;
    m_owner     = 0;
    m_last      = 2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit en_a, input bit en_b);
    exp_t e;
    int   g, other;
    bit   va, vb, skp, vo, vx;
    va = en_a && (qa.size() > 0);
    vb = en_b && (qb.size() > 0);
    valid_a = va;
    valid_b = vb;
    data_a  = va ? qa[0] : 32'h5A5A_0A0A;
    data_b  = vb ? qb[0] : 32'h5A5A_0B0B;
    #1;
    skp = m_active && (m_skp == SKP_INTERVAL - 1);
    g = 0;
    if (m_active && !skp) begin
      if (m_owner != 0) begin
        other = (m_owner == 1) ? 2 : 1;
        vo = (m_owner == 1) ? va : vb;
        vx = (other == 1) ? va : vb;
        if (vo && m_burst < BURST_MAX) g = m_owner;
        else if (vx)                   g = other;
        else if (vo)                   g = m_owner;
      end else if (va && vb) begin
        g = (m_last == 1) ? 2 : 1;
      end else begin
        g = va ? 1 : (vb ? 2 : 0);
      end
    end
    check("ready_a", {31'b0, ready_a}, {31'b0, g == 1});
    check("ready_b", {31'b0, ready_b}, {31'b0, g == 2});
    check("ready_without_valid", {30'b0, ready_b & ~valid_b, ready_a & ~valid_a}, 32'h0);

    if (!m_active) begin
      e = '{d: 32'hBCBC_BCBC, v: 1'b0, k: 1'b1, g: 2'b00, s: 1'b0};
    end else if (skp) begin
      e = '{d: 32'h1C1C_1C1C, v: 1'b0, k: 1'b1, g: 2'b00, s: 1'b1};
    end else if (g == 1) begin
      e = '{d: qa[0], v: 1'b1, k: 1'b0, g: 2'b01, s: 1'b1};
    end else if (g == 2) begin
      e = '{d: qb[0], v: 1'b1, k: 1'b0, g: 2'b10, s: 1'b1};
    end else begin
      e = '{d: 32'h7C7C_7C7C, v: 1'b0, k: 1'b1, g: 2'b00, s: 1'b1};
    end
    sb.push_back(e);
    if (g == 1) void'(qa.pop_front());
    if (g == 2) void'(qb.pop_front());

    if (!m_active) begin
      m_sync_left--;
      if (m_sync_left == 0) m_active = 1;
    end else begin
      m_skp = skp ? 0 : m_skp + 1;
      if (g != 0) begin
        m_burst = (g != m_owner || m_burst == BURST_MAX) ? 1 : m_burst + 1;
        m_owner = g;
        m_last  = g;
      end else if (!skp) begin
        m_owner = 0;
        m_burst = 0;
      end
    end

    @(posedge clk_2f);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check("data_out", data_out, e.d);
      check("valid_out", {31'b0, valid_out}, {31'b0, e.v});
      check("kword_out", {31'b0, kword_out}, {31'b0, e.k});
      check("grant_out", {30'b0, grant_out}, {30'b0, e.g});
      check("sync_done", {31'b0, sync_done}, {31'b0, e.s});
    end
  endtask

  task automatic check_reset_state();
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid_out", {31'b0, valid_out}, 32'h0);
    check("rst_kword_out", {31'b0, kword_out}, 32'h0);
    check("rst_grant_out", {30'b0, grant_out}, 32'h0);
    check("rst_sync_done", {31'b0, sync_done}, 32'h0);
    check("rst_readies", {30'b0, ready_b, ready_a}, 32'h0);
  endtask

  initial begin
    reset   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    model_reset();
    #2;
    check_reset_state();
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b1;

    // Sync preamble, then IDLE fill.
    repeat (10) cycle(0, 0);

    // Single source A, fixed order.
    qa.push_back(32'hFFFF_FFFF);
    qa.push_back(32'hEEEE_EEEE);
    qa.push_back(32'hDDDD_DDDD);
    repeat (6) cycle(1, 0);

    // Both sources saturated across several SKP slots.
    for (int i = 0; i < 40; i++) begin
      qa.push_back(32'hA000_0000 + i);
      qb.push_back(32'hB000_0000 + i);
    end
    repeat (48) cycle(1, 1);
    qa.delete();
    qb.delete();
    repeat (2) cycle(0, 0);

    // Last served A, then both raise together.
    qa.push_back(32'h1111_0001);
    repeat (2) cycle(1, 0);
    cycle(0, 0);
    qa.push_back(32'h2222_0001);
    qa.push_back(32'h2222_0002);
    qb.push_back(32'h3333_0001);
    qb.push_back(32'h3333_0002);
    repeat (6) cycle(1, 1);

    // A toggles 1,1,0,1 with a gap.
    qa.push_back(32'h4444_0001);
    qa.push_back(32'h4444_0002);
    qa.push_back(32'h4444_0003);
    cycle(1, 0);
    cycle(1, 0);
    cycle(0, 0);
    cycle(1, 0);
    repeat (2) cycle(0, 0);

    // Reset mid-burst.
    for (int i = 0; i < 8; i++) begin
      qa.push_back(32'h5500_0000 + i);
      qb.push_back(32'h6600_0000 + i);
    end
    repeat (3) cycle(1, 1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state();
    valid_a = 1'b0;
    valid_b = 1'b0;
    sb.delete();
    qa.delete();
    qb.delete();
    model_reset();
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b1;
    repeat (8) cycle(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
